id_ex_hazard_stage: RTL
=======================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and bubble insertion.
- Latches decoded operands and control from ID.
- Supplies the registered rs/rt/rd, ALUSrc, MemRead and RegWrite fields consumed by the EX-stage forwarding logic.
- Generates the one-cycle stall for the PC and IF/ID register. Keeps a saturating stall-cycle counter for performance debug.

Parameters:
DATA_WIDTH, 32, width of operand, immediate and PC fields
CNT_WIDTH, 16, width of stall-cycle counter

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Hold  input  1  global freeze (memory wait); register holds all state
Flush  input  1  branch/jump taken; squash instruction entering EX
IF_ID_rs  input  5  source reg rs of instruction in ID
IF_ID_rt  input  5  source reg rt of instruction in ID
IF_ID_rd  input  5  dest reg rd of instruction in ID
IF_ID_UsesRt  input  1  ID instruction reads rt as a source
RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in  input  1 each  decoded control
ALUSrc_in  input  2  2'b10 = immediate form (dest is rt); others register form
ALUOp_in  input  4  ALU operation
ReadData1_in, ReadData2_in, Imm_in, PCPlus4_in  input  DATA_WIDTH each  ID operands
ID_EX_rs, ID_EX_rt, ID_EX_rd  output  5 each  registered register numbers
ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg  output  1 each  registered control
ID_EX_ALUSrc  output  2  registered
ID_EX_ALUOp  output  4  registered
ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PCPlus4  output  DATA_WIDTH each  registered
ID_EX_Valid  output  1  1 = real instruction in EX, 0 = bubble
Stall  output  1  combinational; 1 = hold PC and IF/ID this cycle
StallCount  output  CNT_WIDTH  saturating count of cycles with Stall=1

Behaviour:
- Reset, asynchronous: all registered outputs 0, ID_EX_Valid=0, StallCount=0. Stall is 0 while Reset is high.
- Hazard definition:
  - hazard = ID_EX_Valid & ID_EX_MemRead & (ID_EX_rt != 0) & ((ID_EX_rt == IF_ID_rs) | (IF_ID_UsesRt & ID_EX_rt == IF_ID_rt)).
  - The load destination is always rt.
- Stall = hazard & ~Hold & ~Flush & ~Reset. Purely combinational from registered state and ID inputs; no cycle of latency.
- Per rising edge, priority order:
  1. Hold: every register keeps its value, including Valid and StallCount.
  2. Flush: load a bubble.
  3. Stall: load a bubble.
  4. Else: load all *_in fields; ID_EX_Valid=1.
- Bubble:
  - All control outputs 0, including ALUSrc and ALUOp; ID_EX_Valid=0.
  - rs/rt/rd = 0 so downstream match logic sees register 0.
  - Data fields = 0.
- Stall length: exactly 1 cycle per load-use pair. After the bubble, ID_EX_MemRead=0, so the hazard clears. The held ID instruction issues on the following edge, and EX-side forwarding then supplies the load result from MEM/WB.
- Back-to-back loads:
  - lw r2 followed by lw r3,0(r2): 1 stall.
  - lw r3 followed by an add using r3: a further 1 stall.
- Flush coincident with hazard: Stall=0 (the wrong-path ID instruction is discarded upstream) and a bubble is loaded.
- Hold coincident with hazard: Stall=0, StallCount unchanged. The hazard re-evaluates after Hold drops.
- StallCount:
  - Increments by 1 on each edge where Stall=1.
  - Saturates at all-ones (no wrap).
  - Cleared only by Reset.
- Register 0: a load to r0 never stalls.
- Reset mid-stall: outputs clear immediately; the next edge after Reset deasserts follows normal priority.

Test Plan:
1. Reset asserted mid-cycle with Valid=1 and StallCount=5 -> all outputs 0 immediately; Stall=0; StallCount=0.
2. lw $2 in EX (MemRead=1, rt=2, Valid=1), ID has add $4,$2,$3 (rs=2) -> Stall=1 for 1 cycle. Next EX holds a bubble (Valid=0, RegWrite=0). The add enters EX one edge later; StallCount=1.
3. lw $2 in EX, ID has sw $2 with UsesRt=1, rt=2, rs=5 -> Stall=1. Same case with UsesRt=0 (e.g. addi writing rt=2) -> Stall=0.
4. lw $0 in EX, ID rs=0 -> Stall=0; instruction loads normally with Valid=1.
5. Hazard present with Flush=1 -> Stall=0 and bubble loaded. Hazard present with Hold=1 for 3 cycles -> outputs frozen, Stall=0, StallCount unchanged. Hold drops -> Stall=1.
6. CNT_WIDTH=4; force 17 stall cycles via repeated load-use pairs -> StallCount stops at 15.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating stall-cycle counter for performance debug.
module id_ex_hazard_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Hold,
    input  logic                  Flush,
    input  logic [4:0]            IF_ID_rs,
    input  logic [4:0]            IF_ID_rt,
    input  logic [4:0]            IF_ID_rd,
    input  logic                  IF_ID_UsesRt,
    input  logic                  RegWrite_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  MemToReg_in,
    input  logic [1:0]            ALUSrc_in,
    input  logic [3:0]            ALUOp_in,
    input  logic [DATA_WIDTH-1:0] ReadData1_in,
    input  logic [DATA_WIDTH-1:0] ReadData2_in,
    input  logic [DATA_WIDTH-1:0] Imm_in,
    input  logic [DATA_WIDTH-1:0] PCPlus4_in,
    output logic [4:0]            ID_EX_rs,
    output logic [4:0]            ID_EX_rt,
    output logic [4:0]            ID_EX_rd,
    output logic                  ID_EX_RegWrite,
    output logic                  ID_EX_MemRead,
    output logic                  ID_EX_MemWrite,
    output logic                  ID_EX_MemToReg,
    output logic [1:0]            ID_EX_ALUSrc,
    output logic [3:0]            ID_EX_ALUOp,
    output logic [DATA_WIDTH-1:0] ID_EX_ReadData1,
    output logic [DATA_WIDTH-1:0] ID_EX_ReadData2,
    output logic [DATA_WIDTH-1:0] ID_EX_Imm,
    output logic [DATA_WIDTH-1:0] ID_EX_PCPlus4,
    output logic                  ID_EX_Valid,
    output logic                  Stall,
    output logic [CNT_WIDTH-1:0]  StallCount
);

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_W-1:0]      rs;
        logic [REG_W-1:0]      rt;
        logic [REG_W-1:0]      rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic [1:0]            alu_src;
        logic [3:0]            alu_op;
        logic [DATA_WIDTH-1:0] read_data1;
        logic [DATA_WIDTH-1:0] read_data2;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] pc_plus4;
    } ex_slot_t;

    ex_slot_t             slot_q, slot_d, issue_c;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rs_hit_c, rt_hit_c, hazard_c, stall_c;

    // Instruction presented by ID, packed as it would sit in EX.
    always_comb begin
        issue_c            = '0;
        issue_c.valid      = 1'b1;
        issue_c.rs         = IF_ID_rs;
        issue_c.rt         = IF_ID_rt;
        issue_c.rd         = IF_ID_rd;
        issue_c.reg_write  = RegWrite_in;
        issue_c.mem_read   = MemRead_in;
        issue_c.mem_write  = MemWrite_in;
        issue_c.mem_to_reg = MemToReg_in;
        issue_c.alu_src    = ALUSrc_in;
        issue_c.alu_op     = ALUOp_in;
        issue_c.read_data1 = ReadData1_in;
        issue_c.read_data2 = ReadData2_in;
        issue_c.imm        = Imm_in;
        issue_c.pc_plus4   = PCPlus4_in;
    end

    // A load in EX always targets rt; r0 is never a real dependency.
    always_comb begin
        rs_hit_c = (slot_q.rt == IF_ID_rs);
        rt_hit_c = IF_ID_UsesRt & (slot_q.rt == IF_ID_rt);
        hazard_c = slot_q.valid & slot_q.mem_read & (slot_q.rt != REG_W'(0))
                 & (rs_hit_c | rt_hit_c);
        stall_c  = hazard_c & ~Hold & ~Flush & ~Reset;
    end

    // Next state: Hold freezes everything, Flush/Stall load a bubble.
    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (!Hold) begin
            if (Flush || stall_c) begin
                slot_d = '0;
            end else begin
                slot_d = issue_c;
            end
            if (stall_c && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_q <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ID_EX_Valid     = slot_q.valid;
    assign ID_EX_rs        = slot_q.rs;
    assign ID_EX_rt        = slot_q.rt;
    assign ID_EX_rd        = slot_q.rd;
    assign ID_EX_RegWrite  = slot_q.reg_write;
    assign ID_EX_MemRead   = slot_q.mem_read;
    assign ID_EX_MemWrite  = slot_q.mem_write;
    assign ID_EX_MemToReg  = slot_q.mem_to_reg;
    assign ID_EX_ALUSrc    = slot_q.alu_src;
    assign ID_EX_ALUOp     = slot_q.alu_op;
    assign ID_EX_ReadData1 = slot_q.read_data1;
    assign ID_EX_ReadData2 = slot_q.read_data2;
    assign ID_EX_Imm       = slot_q.imm;
    assign ID_EX_PCPlus4   = slot_q.pc_plus4;
    assign Stall           = stall_c;
    assign StallCount      = cnt_q;

endmodule
